// File: rtl/interrupt_sequencer.sv
// Pipeline-side interrupt sequencer: waits for a safe point, drains the pipeline,
// signals the trap to CP0, redirects fetch to the handler and sequences ERET back.
module interrupt_sequencer #(
  parameter logic [31:0] HANDLER_VECTOR = 32'h0000_0180,
  parameter int unsigned DRAIN_CYCLES   = 2,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             InterruptRequest,
  input  logic             MemBusy,
  input  logic [31:0]      PCCurrent,
  input  logic             InDelaySlot,
  input  logic             EretValid,
  input  logic [31:0]      EPCIn,
  output logic             InterruptHandled,
  output logic [31:0]      InterruptedPC,
  output logic             Stall,
  output logic             Flush,
  output logic             PCRedirect,
  output logic [31:0]      RedirectTarget,
  output logic             InHandler,
  output logic [CNT_W-1:0] TakenCount
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DRAIN   = 3'd1,
    S_TRAP    = 3'd2,
    S_HANDLER = 3'd3,
    S_RETURN  = 3'd4
  } state_t;

  localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_CYCLES - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  state_t           state_q, state_d;
  logic [2:0]       drain_q, drain_d;
  logic [31:0]      cap_pc_q, cap_pc_d;
  logic             handled_q, handled_d;
  logic [31:0]      ipc_q, ipc_d;
  logic             stall_q, stall_d;
  logic             flush_q, flush_d;
  logic             redir_q, redir_d;
  logic [31:0]      tgt_q, tgt_d;
  logic             inh_q, inh_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             take;

  assign take = InterruptRequest & ~MemBusy & ~EretValid;

  always_comb begin
    state_d  = state_q;
    drain_d  = drain_q;
    cap_pc_d = cap_pc_q;
    unique case (state_q)
      S_IDLE: begin
        // A stray ERET wins over a simultaneous request.
        if (EretValid) begin
          state_d = S_RETURN;
        end else if (take) begin
          cap_pc_d = InDelaySlot ? (PCCurrent - 32'd4) : PCCurrent;
          drain_d  = DRAIN_LOAD;
          state_d  = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (drain_q == 3'd0) state_d = S_TRAP;
        else                 drain_d = drain_q - 3'd1;
      end
      S_TRAP:    state_d = S_HANDLER;
      S_HANDLER: if (EretValid) state_d = S_RETURN;
      S_RETURN:  state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Outputs are a registered function of the state being entered.
  always_comb begin
    handled_d = 1'b0;
    stall_d   = 1'b0;
    flush_d   = 1'b0;
    redir_d   = 1'b0;
    inh_d     = 1'b0;
    ipc_d     = ipc_q;
    tgt_d     = tgt_q;
    cnt_d     = cnt_q;
    unique case (state_d)
      S_DRAIN: begin
        stall_d = 1'b1;
        flush_d = 1'b1;
      end
      S_TRAP: begin
        handled_d = 1'b1;
        ipc_d     = cap_pc_q;
        redir_d   = 1'b1;
        tgt_d     = HANDLER_VECTOR;
        flush_d   = 1'b1;
        cnt_d     = sat_inc(cnt_q);
      end
      S_HANDLER: inh_d = 1'b1;
      S_RETURN: begin
        flush_d = 1'b1;
        redir_d = 1'b1;
        tgt_d   = EPCIn;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q   <= S_IDLE;
      drain_q   <= 3'd0;
      cap_pc_q  <= 32'd0;
      handled_q <= 1'b0;
      ipc_q     <= 32'd0;
      stall_q   <= 1'b0;
      flush_q   <= 1'b0;
      redir_q   <= 1'b0;
      tgt_q     <= 32'd0;
      inh_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      drain_q   <= drain_d;
      cap_pc_q  <= cap_pc_d;
      handled_q <= handled_d;
      ipc_q     <= ipc_d;
      stall_q   <= stall_d;
      flush_q   <= flush_d;
      redir_q   <= redir_d;
      tgt_q     <= tgt_d;
      inh_q     <= inh_d;
      cnt_q     <= cnt_d;
    end
  end

  assign InterruptHandled = handled_q;
  assign InterruptedPC    = ipc_q;
  assign Stall            = stall_q;
  assign Flush            = flush_q;
  assign PCRedirect       = redir_q;
  assign RedirectTarget   = tgt_q;
  assign InHandler        = inh_q;
  assign TakenCount       = cnt_q;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Bench for interrupt_sequencer: vector table, hand sequences, and random traffic
// against a cycle-level behavioural model; a narrow-counter instance covers saturation.
module tb_interrupt_sequencer;

  localparam int          DRAIN = 2;
  localparam logic [31:0] VEC   = 32'h0000_0180;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0, busy = 1'b0, ds = 1'b0, eret = 1'b0;
  logic [31:0] pc = 32'd0, epc = 32'd0;

  logic        hand, stall, flush, redir, inh;
  logic [31:0] ipc, tgt;
  logic [15:0] cnt;
  logic        s_hand, s_stall, s_flush, s_redir, s_inh;
  logic [31:0] s_ipc, s_tgt;
  logic [1:0]  s_cnt;

  always #5 clk = ~clk;

  interrupt_sequencer #(.HANDLER_VECTOR(VEC), .DRAIN_CYCLES(DRAIN), .CNT_W(16)) dut (
    .Clock(clk), .Reset(rst_n), .InterruptRequest(req), .MemBusy(busy),
    .PCCurrent(pc), .InDelaySlot(ds), .EretValid(eret), .EPCIn(epc),
    .InterruptHandled(hand), .InterruptedPC(ipc), .Stall(stall), .Flush(flush),
    .PCRedirect(redir), .RedirectTarget(tgt), .InHandler(inh), .TakenCount(cnt)
  );

  interrupt_sequencer #(.HANDLER_VECTOR(VEC), .DRAIN_CYCLES(DRAIN), .CNT_W(2)) dut_sat (
    .Clock(clk), .Reset(rst_n), .InterruptRequest(req), .MemBusy(busy),
    .PCCurrent(pc), .InDelaySlot(ds), .EretValid(eret), .EPCIn(epc),
    .InterruptHandled(s_hand), .InterruptedPC(s_ipc), .Stall(s_stall), .Flush(s_flush),
    .PCRedirect(s_redir), .RedirectTarget(s_tgt), .InHandler(s_inh), .TakenCount(s_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: cycles left in the drain, one-shot trap/return flags,
  // handler-active flag, captured restart PC, ERET target and total traps taken.
  int          m_drain;
  bit          m_trap, m_ret, m_inh;
  logic [31:0] m_cap, m_epc;
  int          m_cnt;

  task automatic model_reset();
    m_drain = 0; m_trap = 0; m_ret = 0; m_inh = 0;
    m_cap = 32'd0; m_epc = 32'd0; m_cnt = 0;
  endtask

  task automatic model_step();
    if (m_drain > 0) begin
      m_drain = m_drain - 1;
      if (m_drain == 0) begin
        m_trap = 1;
        m_cnt  = m_cnt + 1;
      end
    end else if (m_trap) begin
      m_trap = 0;
      m_inh  = 1;
    end else if (m_ret) begin
      m_ret = 0;
    end else if (m_inh) begin
      if (eret) begin
        m_inh = 0; m_ret = 1; m_epc = epc;
      end
    end else if (eret) begin
      m_ret = 1; m_epc = epc;
    end else if (req && !busy) begin
      m_drain = DRAIN;
      m_cap   = ds ? pc - 32'd4 : pc;
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    logic [4:0]  ectl;
    logic [15:0] ecnt;
    logic [1:0]  escnt;
    ectl  = {m_drain > 0, (m_drain > 0) || m_trap || m_ret, m_trap, m_trap || m_ret, m_inh};
    ecnt  = (m_cnt > 65535) ? 16'hFFFF : 16'(m_cnt);
    escnt = (m_cnt > 3) ? 2'd3 : 2'(m_cnt);
    chk({tag, "_ctl"}, 64'({stall, flush, hand, redir, inh}), 64'(ectl));
    chk({tag, "_sctl"}, 64'({s_stall, s_flush, s_hand, s_redir, s_inh}), 64'(ectl));
    chk({tag, "_cnt"}, 64'(cnt), 64'(ecnt));
    chk({tag, "_scnt"}, 64'(s_cnt), 64'(escnt));
    if (m_trap) begin
      chk({tag, "_ipc"}, 64'(ipc), 64'(m_cap));
      chk({tag, "_tgt"}, 64'(tgt), 64'(VEC));
      chk({tag, "_sipc"}, 64'(s_ipc), 64'(m_cap));
    end
    if (m_ret) begin
      chk({tag, "_tgt"}, 64'(tgt), 64'(m_epc));
      chk({tag, "_stgt"}, 64'(s_tgt), 64'(m_epc));
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_model(tag);
  endtask

  task automatic set_in(input logic r, input logic b, input logic d, input logic e,
                        input logic [31:0] p, input logic [31:0] ep);
    req = r; busy = b; ds = d; eret = e; pc = p; epc = ep;
  endtask

  typedef struct {
    logic        req, busy, ds, eret;
    logic [31:0] pc, epc;
    logic [4:0]  ctl;   // {Stall, Flush, InterruptHandled, PCRedirect, InHandler}
    logic [31:0] ipc, tgt;
    logic [15:0] cnt;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic b, input logic d, input logic e,
                              input logic [31:0] p, input logic [31:0] ep, input logic [4:0] c,
                              input logic [31:0] ip, input logic [31:0] tg, input logic [15:0] n);
    vec_t v;
    v.req = r; v.busy = b; v.ds = d; v.eret = e; v.pc = p; v.epc = ep;
    v.ctl = c; v.ipc = ip; v.tgt = tg; v.cnt = n;
    return v;
  endfunction

  vec_t tbl[21];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = mk(1, 0, 0, 0, 32'h40,  32'h0,   5'b11000, 32'h0,        32'h0,   16'd0);
    tbl[1]  = mk(1, 0, 0, 0, 32'h40,  32'h0,   5'b11000, 32'h0,        32'h0,   16'd0);
    tbl[2]  = mk(0, 0, 0, 0, 32'h40,  32'h0,   5'b01110, 32'h40,       VEC,     16'd1);
    tbl[3]  = mk(1, 0, 0, 0, 32'h40,  32'h0,   5'b00001, 32'h0,        32'h0,   16'd1);
    tbl[4]  = mk(1, 0, 0, 0, 32'h40,  32'h0,   5'b00001, 32'h0,        32'h0,   16'd1);
    tbl[5]  = mk(0, 0, 0, 1, 32'h40,  32'h40,  5'b01010, 32'h0,        32'h40,  16'd1);
    tbl[6]  = mk(0, 0, 0, 0, 32'h40,  32'h0,   5'b00000, 32'h0,        32'h0,   16'd1);
    tbl[7]  = mk(1, 0, 1, 0, 32'h100, 32'h0,   5'b11000, 32'h0,        32'h0,   16'd1);
    tbl[8]  = mk(0, 0, 0, 0, 32'h100, 32'h0,   5'b11000, 32'h0,        32'h0,   16'd1);
    tbl[9]  = mk(0, 0, 0, 0, 32'h100, 32'h0,   5'b01110, 32'hFC,       VEC,     16'd2);
    tbl[10] = mk(0, 0, 0, 0, 32'h100, 32'h0,   5'b00001, 32'h0,        32'h0,   16'd2);
    tbl[11] = mk(0, 0, 0, 1, 32'h100, 32'h104, 5'b01010, 32'h0,        32'h104, 16'd2);
    tbl[12] = mk(0, 0, 0, 0, 32'h40,  32'h0,   5'b00000, 32'h0,        32'h0,   16'd2);
    tbl[13] = mk(1, 0, 0, 1, 32'h40,  32'h200, 5'b01010, 32'h0,        32'h200, 16'd2);
    tbl[14] = mk(1, 0, 0, 0, 32'h40,  32'h0,   5'b00000, 32'h0,        32'h0,   16'd2);
    tbl[15] = mk(1, 0, 1, 0, 32'h0,   32'h0,   5'b11000, 32'h0,        32'h0,   16'd2);
    tbl[16] = mk(0, 0, 0, 0, 32'h0,   32'h0,   5'b11000, 32'h0,        32'h0,   16'd2);
    tbl[17] = mk(0, 0, 0, 0, 32'h0,   32'h0,   5'b01110, 32'hFFFFFFFC, VEC,     16'd3);
    tbl[18] = mk(0, 0, 0, 0, 32'h0,   32'h0,   5'b00001, 32'h0,        32'h0,   16'd3);
    tbl[19] = mk(0, 0, 0, 1, 32'h0,   32'h300, 5'b01010, 32'h0,        32'h300, 16'd3);
    tbl[20] = mk(0, 0, 0, 0, 32'h0,   32'h0,   5'b00000, 32'h0,        32'h0,   16'd3);

    // Reset state
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_ctl", 64'({stall, flush, hand, redir, inh}), 64'd0);
    chk("reset_ipc", 64'(ipc), 64'd0);
    chk("reset_tgt", 64'(tgt), 64'd0);
    chk("reset_cnt", 64'(cnt), 64'd0);
    chk("reset_scnt", 64'(s_cnt), 64'd0);
    rst_n = 1'b1;

    // Directed vectors
    for (int i = 0; i < 21; i++) begin
      set_in(tbl[i].req, tbl[i].busy, tbl[i].ds, tbl[i].eret, tbl[i].pc, tbl[i].epc);
      step($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_tctl", i), 64'({stall, flush, hand, redir, inh}), 64'(tbl[i].ctl));
      chk($sformatf("vec%0d_tcnt", i), 64'(cnt), 64'(tbl[i].cnt));
      if (tbl[i].ctl[2]) chk($sformatf("vec%0d_tipc", i), 64'(ipc), 64'(tbl[i].ipc));
      if (tbl[i].ctl[1]) chk($sformatf("vec%0d_ttgt", i), 64'(tgt), 64'(tbl[i].tgt));
    end

    // MemBusy defers the take; the drain starts the cycle after it drops
    for (int i = 0; i < 5; i++) begin
      set_in(1, 1, 0, 0, 32'h500, 32'h0);
      step("busy");
      chk("busy_nostall", 64'({stall, hand}), 64'd0);
    end
    set_in(1, 0, 0, 0, 32'h500, 32'h0);
    step("busy_drop");
    chk("busy_drain_start", 64'({stall, flush}), 64'b11);
    set_in(0, 0, 0, 0, 32'h0, 32'h0);
    step("busy_d2");
    step("busy_trap");
    chk("busy_trap_pulse", 64'(hand), 64'd1);
    chk("busy_trap_ipc", 64'(ipc), 64'h500);

    // Requests inside the handler must not nest
    for (int i = 0; i < 10; i++) begin
      set_in(1, 0, 0, 0, 32'h600, 32'h0);
      step("nest");
      chk("nest_nopulse", 64'({hand, inh}), 64'b01);
    end
    set_in(0, 0, 0, 1, 32'h0, 32'h40);
    step("eret");
    chk("eret_ctl", 64'({redir, flush, inh}), 64'b110);
    chk("eret_tgt", 64'(tgt), 64'h40);
    set_in(0, 0, 0, 0, 32'h0, 32'h0);
    step("eret_idle");

    // Narrow counter saturates while the wide one keeps counting
    chk("sat_narrow", 64'(s_cnt), 64'd3);
    chk("sat_wide", 64'(cnt), 64'd4);

    // Asynchronous reset in the middle of a drain
    set_in(1, 0, 0, 0, 32'h700, 32'h0);
    step("rst_take");
    chk("rst_in_drain", 64'(stall), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_ctl", 64'({stall, flush, hand, redir, inh}), 64'd0);
    chk("rst_async_data", 64'({ipc, tgt}), 64'd0);
    chk("rst_async_cnt", 64'({cnt, s_cnt}), 64'd0);
    model_reset();
    req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step("post_rst");
      chk("post_rst_nopulse", 64'(hand), 64'd0);
    end

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      req  = ($urandom_range(0, 3) != 0);
      busy = ($urandom_range(0, 3) == 0);
      eret = ($urandom_range(0, 9) == 0);
      ds   = 1'($urandom_range(0, 1));
      pc   = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
      epc  = $urandom;
      step("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
